// File: rtl/spi_slave_if_if.sv
// Bundles the SPI pins and the command-decoder side of spi_slave_if.
// The slave modport is the design's view; master is the driver/observer view.
interface spi_slave_if_if;
  logic        sck;
  logic        ssel;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  tx_data;
  logic        cmd_ready;
  logic        param_ready;
  logic [7:0]  cmd_data;
  logic [7:0]  param_data;
  logic [31:0] byte_cnt;
  logic [2:0]  bit_cnt;

  modport slave (
    input  sck, ssel, mosi, tx_data,
    output miso, miso_oe, cmd_ready, param_ready, cmd_data, param_data, byte_cnt, bit_cnt
  );

  modport master (
    output sck, ssel, mosi, tx_data,
    input  miso, miso_oe, cmd_ready, param_ready, cmd_data, param_data, byte_cnt, bit_cnt
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: oversamples SCK/SSEL/MOSI in the clk domain, deframes command
// and parameter bytes, and shifts the decoder's reply byte out on MISO.
module spi_slave_if (
  input  logic               clk,
  input  logic               rst_n,
  spi_slave_if_if.slave      bus
);

  logic [2:0]  sck_q, ssel_q, mosi_q;
  logic        sck_rise, sck_fall, ssel_act, ssel_start;

  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d, byte_inc;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [7:0]  param_data_q, param_data_d;
  logic        byte_done_q, byte_done_d;
  logic        byte_is_cmd_q, byte_is_cmd_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        param_ready_q, param_ready_d;

  // Synchronized ssel resets inactive so a reset never fabricates a transaction start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      ssel_q <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sck_q  <= {sck_q[1:0], bus.sck};
      ssel_q <= {ssel_q[1:0], bus.ssel};
      mosi_q <= {mosi_q[1:0], bus.mosi};
    end
  end

  assign sck_rise   = sck_q[1] & ~sck_q[2];
  assign sck_fall   = ~sck_q[1] & sck_q[2];
  assign ssel_act   = ~ssel_q[1];
  assign ssel_start = ~ssel_q[1] & ssel_q[2];

  always_comb begin
    rx_d          = rx_q;
    tx_d          = tx_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    cmd_data_d    = cmd_data_q;
    param_data_d  = param_data_q;
    byte_done_d   = 1'b0;
    byte_is_cmd_d = 1'b0;
    byte_inc      = byte_cnt_q + 32'd1;
    // Ready pulses trail the byte-complete shift by one clk.
    cmd_ready_d   = byte_done_q & byte_is_cmd_q & ssel_act;
    param_ready_d = byte_done_q & ~byte_is_cmd_q & ssel_act;

    if (!ssel_act) begin
      rx_d       = 8'h00;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 32'd0;
    end else begin
      if (sck_rise) begin
        rx_d      = {rx_q[6:0], mosi_q[1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_cnt_d    = byte_inc;
          byte_done_d   = 1'b1;
          byte_is_cmd_d = (byte_inc == 32'd1);
          if (byte_inc == 32'd1) begin
            cmd_data_d = rx_d;
          end else begin
            param_data_d = rx_d;
          end
        end
      end
      // Reply byte is reloaded at transaction start and on each byte-boundary falling edge.
      if (ssel_start || (sck_fall && (bit_cnt_q == 3'd0))) begin
        tx_d = bus.tx_data;
      end else if (sck_fall) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 32'd0;
      cmd_data_q    <= 8'h00;
      param_data_q  <= 8'h00;
      byte_done_q   <= 1'b0;
      byte_is_cmd_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      param_ready_q <= 1'b0;
    end else begin
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      cmd_data_q    <= cmd_data_d;
      param_data_q  <= param_data_d;
      byte_done_q   <= byte_done_d;
      byte_is_cmd_q <= byte_is_cmd_d;
      cmd_ready_q   <= cmd_ready_d;
      param_ready_q <= param_ready_d;
    end
  end

  assign bus.miso        = ssel_act & tx_q[7];
  assign bus.miso_oe     = ssel_act;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.param_ready = param_ready_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.param_data  = param_data_q;
  assign bus.byte_cnt    = byte_cnt_q;
  assign bus.bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: an SPI mode-0 master at clk/SCK = 8 plus a
// negedge monitor capturing every ready pulse.
module tb_spi_slave_if;

  localparam time Half = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if_if bus ();

  spi_slave_if dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       echo = 1'b0;
  logic [7:0] tx_reg = 8'h00;
  assign bus.tx_data = echo ? bus.param_data : tx_reg;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ready-pulse monitor
  int          cmd_pulses = 0;
  int          param_pulses = 0;
  int          long_pulses = 0;
  logic        prev_ready = 1'b0;
  logic [7:0]  cmd_cap = 8'h00;
  logic [31:0] cmd_bc = 32'd0;
  logic [7:0]  p_data_q[$];
  logic [31:0] p_bc_q[$];
  logic [2:0]  p_bit_q[$];

  always @(negedge clk) begin
    if (bus.cmd_ready) begin
      cmd_pulses++;
      cmd_cap = bus.cmd_data;
      cmd_bc  = bus.byte_cnt;
    end
    if (bus.param_ready) begin
      param_pulses++;
      p_data_q.push_back(bus.param_data);
      p_bc_q.push_back(bus.byte_cnt);
      p_bit_q.push_back(bus.bit_cnt);
    end
    if ((bus.cmd_ready || bus.param_ready) && prev_ready) long_pulses++;
    prev_ready = bus.cmd_ready | bus.param_ready;
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      #Half;
      r = {r[6:0], bus.miso};
      bus.sck = 1'b1;
      #Half;
      bus.sck = 1'b0;
    end
  endtask

  task automatic ssel_on();
    bus.ssel = 1'b0;
    #100;
  endtask

  task automatic ssel_off();
    #Half;
    bus.ssel = 1'b1;
    #100;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_miso"}, 32'(bus.miso), 32'd0);
    check_eq({tag, "_miso_oe"}, 32'(bus.miso_oe), 32'd0);
    check_eq({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check_eq({tag, "_param_ready"}, 32'(bus.param_ready), 32'd0);
    check_eq({tag, "_cmd_data"}, 32'(bus.cmd_data), 32'd0);
    check_eq({tag, "_param_data"}, 32'(bus.param_data), 32'd0);
    check_eq({tag, "_byte_cnt"}, bus.byte_cnt, 32'd0);
    check_eq({tag, "_bit_cnt"}, 32'(bus.bit_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] r3, r4;
    logic [7:0] vals[256];
    int c0, p0;
    int phase;

    bus.sck  = 1'b0;
    bus.ssel = 1'b0;
    bus.mosi = 1'b1;

    // Reset held with SCK toggling and ssel low
    for (int i = 0; i < 10; i++) begin
      #Half bus.sck = ~bus.sck;
    end
    bus.sck = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_hold");
    bus.ssel = 1'b1;
    #50;
    rst_n = 1'b1;
    #200;
    @(negedge clk);
    check_idle_outputs("rst_release");

    // Single command, then reply 0xA5 on the next byte
    c0 = cmd_pulses;
    p0 = param_pulses;
    tx_reg = 8'h00;
    ssel_on();
    check_eq("oe_active", 32'(bus.miso_oe), 32'd1);
    tx_reg = 8'hA5;
    spi_bits(8'hF0, 8, r);
    #100;
    check_eq("cmd1_pulses", 32'(cmd_pulses - c0), 32'd1);
    check_eq("cmd1_data", 32'(cmd_cap), 32'hF0);
    check_eq("cmd1_byte_cnt", cmd_bc, 32'd1);
    check_eq("cmd1_no_param", 32'(param_pulses - p0), 32'd0);
    check_eq("cmd1_miso_b1", 32'(r), 32'h00);
    spi_bits(8'h00, 8, r);
    check_eq("cmd1_miso_b2", 32'(r), 32'hA5);
    ssel_off();
    check_eq("cmd1_idle_oe", 32'(bus.miso_oe), 32'd0);
    check_eq("cmd1_idle_byte_cnt", bus.byte_cnt, 32'd0);

    // Command plus three params
    c0 = cmd_pulses;
    p0 = param_pulses;
    ssel_on();
    spi_bits(8'h10, 8, r);
    spi_bits(8'h3F, 8, r);
    spi_bits(8'hFF, 8, r);
    spi_bits(8'hFF, 8, r);
    #100;
    ssel_off();
    check_eq("cp_cmd_pulses", 32'(cmd_pulses - c0), 32'd1);
    check_eq("cp_cmd_data", 32'(cmd_cap), 32'h10);
    check_eq("cp_param_pulses", 32'(param_pulses - p0), 32'd3);
    check_eq("cp_p0_data", 32'(p_data_q[p0]), 32'h3F);
    check_eq("cp_p1_data", 32'(p_data_q[p0+1]), 32'hFF);
    check_eq("cp_p2_data", 32'(p_data_q[p0+2]), 32'hFF);
    check_eq("cp_p0_bc", p_bc_q[p0], 32'd2);
    check_eq("cp_p1_bc", p_bc_q[p0+1], 32'd3);
    check_eq("cp_p2_bc", p_bc_q[p0+2], 32'd4);
    check_eq("cp_p0_bit", 32'(p_bit_q[p0]), 32'd0);
    check_eq("cp_p2_bit", 32'(p_bit_q[p0+2]), 32'd0);
    check_eq("cp_cmd_held", 32'(bus.cmd_data), 32'h10);
    check_eq("cp_param_held", 32'(bus.param_data), 32'hFF);

    // Echo stream: reply lags the received parameter by one byte
    echo = 1'b1;
    ssel_on();
    spi_bits(8'hFF, 8, r);
    spi_bits(8'h11, 8, r);
    spi_bits(8'h22, 8, r3);
    spi_bits(8'h33, 8, r4);
    ssel_off();
    echo = 1'b0;
    check_eq("echo_b3", 32'(r3), 32'h11);
    check_eq("echo_b4", 32'(r4), 32'h22);

    // Abort after 5 bits of byte 2
    c0 = cmd_pulses;
    p0 = param_pulses;
    ssel_on();
    spi_bits(8'h55, 8, r);
    spi_bits(8'hC3, 5, r);
    check_eq("abort_bit_cnt_mid", 32'(bus.bit_cnt), 32'd5);
    ssel_off();
    #100;
    check_eq("abort_no_param", 32'(param_pulses - p0), 32'd0);
    check_eq("abort_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    check_eq("abort_byte_cnt", bus.byte_cnt, 32'd0);
    ssel_on();
    spi_bits(8'h81, 8, r);
    #100;
    ssel_off();
    check_eq("abort_cmd_pulses", 32'(cmd_pulses - c0), 32'd2);
    check_eq("abort_new_cmd", 32'(cmd_cap), 32'h81);
    check_eq("abort_new_bc", cmd_bc, 32'd1);
    check_eq("abort_still_no_param", 32'(param_pulses - p0), 32'd0);

    // 256 bytes at ratio 8 with a random clk phase
    @(negedge clk);
    phase = $urandom_range(0, 8);
    if (phase >= 5) phase++;
    #(phase);
    for (int i = 0; i < 256; i++) vals[i] = 8'($urandom_range(0, 255));
    c0 = cmd_pulses;
    p0 = param_pulses;
    tx_reg = 8'h5A;
    ssel_on();
    for (int i = 0; i < 256; i++) begin
      spi_bits(vals[i], 8, r);
      check_eq($sformatf("stream_miso_%0d", i), 32'(r), 32'h5A);
    end
    #100;
    ssel_off();
    check_eq("stream_cmd", 32'(cmd_cap), 32'(vals[0]));
    check_eq("stream_param_pulses", 32'(param_pulses - p0), 32'd255);
    for (int i = 1; i < 256; i++) begin
      check_eq($sformatf("stream_param_%0d", i), 32'(p_data_q[p0+i-1]), 32'(vals[i]));
    end
    check_eq("stream_last_bc", p_bc_q[p0+254], 32'd256);
    check_eq("pulse_width", 32'(long_pulses), 32'd0);

    // Reset mid-byte
    @(negedge clk);
    ssel_on();
    spi_bits(8'h3C, 8, r);
    spi_bits(8'h00, 4, r);
    #20;
    check_eq("mid_rst_pre_bit", 32'(bus.bit_cnt), 32'd4);
    check_eq("mid_rst_pre_cmd", 32'(bus.cmd_data), 32'h3C);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    bus.ssel = 1'b1;
    #50;
    rst_n = 1'b1;
    #100;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI mode-0 slave front end that sits directly upstream of the MCU command decoder. Oversamples the MCU's SCK/SSEL/MOSI in the FPGA clock domain and deframes each transaction into one command byte followed by parameter bytes. Publishes the byte/bit position so the decoder can index parameters, and shifts the decoder's reply byte back out on MISO.

## Interface
- No parameters.
- clk  in  1  system clock; must be at least 8x SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from MCU, asynchronous; idles low (CPOL=0).
- ssel  in  1  SPI chip select from MCU, active low, asynchronous.
- mosi  in  1  SPI data from MCU, MSB first.
- miso  out  1  SPI data to MCU, MSB first.
- miso_oe  out  1  MISO output enable; 1 while the synchronized ssel is active.
- tx_data  in  8  reply byte from the command decoder; sampled at each byte boundary.
- cmd_ready  out  1  one-clk pulse: first byte of the transaction is complete.
- param_ready  out  1  one-clk pulse: a subsequent byte is complete.
- cmd_data  out  8  command byte; held until the next transaction's first byte completes.
- param_data  out  8  most recent parameter byte; held until the next parameter completes.
- byte_cnt  out  32  bytes completed in the current transaction.
- bit_cnt  out  3  bits received in the current byte, 0..7.

## Operation
- Synchronization:
  - sck, ssel and mosi each pass through a 3-flop shift register.
  - Rising and falling SCK edges are detected from flops 2/3.
  - mosi is sampled from flop 2 on a detected rising edge.
  - ssel_act = ~ssel flop 2.
- Reset values:
  - All outputs 0.
  - Shift registers and synchronizers 0; synchronized ssel resets to inactive (1).
- While ssel_act = 0:
  - bit_cnt and byte_cnt are held at 0 and the RX shift register is cleared.
  - No ready pulses; miso_oe = 0; miso = 0.
  - cmd_data and param_data keep their values.
- Receive:
  - On each detected rising edge with ssel_act: shift in mosi (MSB first); bit_cnt = bit_cnt + 1, wrapping 7 -> 0.
  - On the rising edge that completes a byte (bit_cnt was 7):
    - byte_cnt increments (32-bit, wraps at 2^32-1 -> 0).
    - The completed byte is latched to cmd_data if the new byte_cnt = 1, otherwise to param_data.
  - On the following clk, cmd_ready (new byte_cnt = 1) or param_ready (new byte_cnt >= 2) pulses high for exactly one clk.
  - byte_cnt and the data outputs already hold their new values during that pulse.
- Transmit:
  - TX shift register loads tx_data on the clk that ssel_act rises; miso = TX bit 7 from the next clk.
  - On each detected falling edge:
    - If bit_cnt = 0 (byte boundary), load tx_data.
    - Otherwise shift left by one, filling with 0.
  - miso is always TX bit 7.
- Abort: ssel deasserting mid-byte discards the partial byte and produces no ready pulse. The next transaction restarts at byte_cnt 0 and bit_cnt 0.
- Simultaneous events:
  - ssel deassert detected in the same clk as a completing rising edge: the edge is ignored.
  - ssel has priority over SCK edges.

## Timing
- Edge-detect latency: an SCK edge at the pin is acted on 2-3 clk later.
- Byte latency: ready pulse 1 clk after the shift on the 8th rising edge, i.e. 3-4 clk after that pin edge.
- tx_data must be stable at the first falling edge after a ready pulse.
  - The decoder updates its reply register on the ready pulse, so it is valid 1 clk later.
  - This is well inside the half SCK period available at the required clock ratio.
- Minimum ssel-high time between transactions: 3 clk.
- Asynchronous reset takes effect immediately. Reset mid-transaction drops all state; the first byte after release is treated as a command only if ssel was seen high first (synchronizer resets inactive).
- Back-to-back bytes with no gap: each ready pulse is separated by at least 16 clk at the minimum clock ratio; pulses are never merged.

## Test plan
- Reset: hold rst_n low with sck toggling -> all outputs 0. Release with ssel high -> outputs stay 0.
- Single command: send 0xF0 -> one cmd_ready pulse with cmd_data=0xF0, byte_cnt=1, no param_ready. Then drive tx_data=0xA5 -> next byte clocks out 0xA5 on miso.
- Command plus 3 params: send 0x10,0x3F,0xFF,0xFF -> param_ready pulses with byte_cnt 2,3,4 and param_data 0x3F,0xFF,0xFF in order; bit_cnt reads 0 at each pulse.
- Echo stream: cmd 0xFF, then params 0x11,0x22,0x33 with tx_data looped from param_data -> miso returns 0x11,0x22 in bytes 3,4 (a one-byte lag).
- Abort: raise ssel after 5 bits of byte 2 -> no param_ready; a new transaction's first byte 0x81 gives cmd_ready with byte_cnt=1.
- Edge cases:
  - At a clk/SCK ratio of exactly 8 with random clk phase, no bits are lost across 256 bytes.
  - Asserting rst_n low mid-byte -> outputs return to 0 immediately.
